phase_scheduler: RTL



---
 rtl/phase_sched_pkg.sv | 43 ++++
 rtl/tick_gen.sv | 35 +++
 rtl/phase_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/phase_sched_pkg.sv
// Shared types, lamp encodings and round-robin helper for the intersection phase scheduler.
package phase_sched_pkg;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_ALLRED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MAIN = 2'd0,
        SEC  = 2'd1,
        PED  = 2'd2
    } phase_e;

    localparam logic [2:0] RED3 = 3'b100;
    localparam logic [2:0] YEL3 = 3'b010;
    localparam logic [2:0] GRN3 = 3'b001;
    localparam logic [1:0] PRED = 2'b10;
    localparam logic [1:0] PGRN = 2'b01;
    localparam logic [1:0] POFF = 2'b00;

    // Scan cur+1 then cur+2 (mod 3) for a pending phase; main is the fallback.
    function automatic phase_e next_phase(input phase_e cur, input logic [2:0] pend);
        phase_e nxt;
        nxt = MAIN;
        case (cur)
            MAIN: begin
                if (pend[1])      nxt = SEC;
                else if (pend[2]) nxt = PED;
            end
            SEC: begin
                if (pend[2]) nxt = PED;
            end
            default: begin
                if (!pend[0] && pend[1]) nxt = SEC;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second tick divider; with PED_FLASH_EN it also provides a half-second on/off phase.
module tick_gen #(
    parameter int FPGAFREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
`ifdef PED_FLASH_EN
    ,
    output logic half_o
`endif
);

    localparam int CW = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(FPGAFREQ - 1));

`ifdef PED_FLASH_EN
    // The tick wraps the counter to zero, so the first half of every second reads as "on".
    assign half_o = (cnt_q < CW'(FPGAFREQ / 2));
`endif

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/phase_scheduler.sv
// Intersection phase scheduler: latched requests, round-robin phase selection, timed clearance.
// Define PED_FLASH_EN to flash the pedestrian green during pedestrian clearance.
module phase_scheduler
    import phase_sched_pkg::*;
#(
    parameter int FPGAFREQ   = 50_000_000,
    parameter int T_MINGREEN = 5,
    parameter int T_MAXGREEN = 18,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 2,
    parameter int T_PEDWALK  = 5
) (
    input  logic                              clk,
    input  logic                              nreset,
    input  logic [2:0]                        req,
    input  logic [1:0]                        ext,
    output logic [2:0]                        main_lights,
    output logic [2:0]                        sec_lights,
    output logic [1:0]                        pea_lights,
    output logic [2:0]                        pending,
    output logic [1:0]                        cur_phase,
    output logic [$clog2(T_MAXGREEN+1)-1:0]   sec_left
);

    localparam int SW = $clog2(T_MAXGREEN + 1);
    localparam logic [SW-1:0] GMIN = SW'(T_MINGREEN);
    localparam logic [SW-1:0] GMAX = SW'(T_MAXGREEN);
    localparam logic [SW-1:0] Y1   = SW'(T_YELLOW - 1);
    localparam logic [SW-1:0] A1   = SW'(T_ALLRED - 1);
    localparam logic [SW-1:0] P1   = SW'(T_PEDWALK - 1);

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [2:0]    pend_q, pend_d;
    logic [SW-1:0] secLeft_q, secLeft_d;
    logic [SW-1:0] greenCnt_q, greenCnt_d;

    logic          tick;
    logic [SW-1:0] cntInc;
    logic [2:0]    greenMask;
    logic          exitGreen;
    logic          enterGreen;

`ifdef PED_FLASH_EN
    logic halfOn;
`endif

    tick_gen #(
        .FPGAFREQ(FPGAFREQ)
    ) u_tick (
        .clk   (clk),
        .rst_n (nreset),
        .tick_o(tick)
`ifdef PED_FLASH_EN
        ,
        .half_o(halfOn)
`endif
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_INIT;
            phase_q    <= MAIN;
            pend_q     <= 3'b000;
            secLeft_q  <= A1;
            greenCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            secLeft_q  <= secLeft_d;
            greenCnt_q <= greenCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        secLeft_d  = secLeft_q;
        greenCnt_d = greenCnt_q;
        exitGreen  = 1'b0;
        enterGreen = 1'b0;
        cntInc     = (greenCnt_q >= GMAX) ? GMAX : greenCnt_q + SW'(1);
        greenMask  = (state_q == S_GREEN) ? (3'b001 << phase_q) : 3'b000;
        pend_d     = pend_q | (req & ~greenMask);

        case (state_q)
            S_INIT: begin
                if (tick) begin
                    if (secLeft_q == '0) begin
                        enterGreen = 1'b1;
                        phase_d    = MAIN;
                    end else begin
                        secLeft_d = secLeft_q - SW'(1);
                    end
                end
            end
            S_GREEN: begin
                if (tick) begin
                    greenCnt_d = cntInc;
                    case (phase_q)
                        MAIN: exitGreen = (pend_q[1] | pend_q[2]) &&
                                          ((cntInc >= GMIN && !ext[0]) || cntInc >= GMAX);
                        SEC:  exitGreen = (cntInc >= GMIN && !ext[1]) || cntInc >= GMAX;
                        default: begin
                            exitGreen = (secLeft_q == '0);
                            secLeft_d = secLeft_q - SW'(1);
                        end
                    endcase
                    if (exitGreen) begin
                        state_d   = S_YELLOW;
                        secLeft_d = Y1;
                    end
                end
            end
            S_YELLOW: begin
                if (tick) begin
                    if (secLeft_q == '0) begin
                        state_d   = S_ALLRED;
                        secLeft_d = A1;
                    end else begin
                        secLeft_d = secLeft_q - SW'(1);
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (secLeft_q == '0) begin
                        enterGreen = 1'b1;
                        phase_d    = next_phase(phase_q, pend_q);
                    end else begin
                        secLeft_d = secLeft_q - SW'(1);
                    end
                end
            end
        endcase

        // Entering a green clears that phase's request even if it is re-requested this cycle.
        if (enterGreen) begin
            state_d    = S_GREEN;
            greenCnt_d = '0;
            secLeft_d  = (phase_d == PED) ? P1 : '0;
            pend_d     = pend_d & ~(3'b001 << phase_d);
        end
    end

    always_comb begin
        main_lights = RED3;
        sec_lights  = RED3;
        pea_lights  = PRED;
        pending     = pend_q;
        cur_phase   = phase_q;
        sec_left    = secLeft_q;
        case (state_q)
            S_GREEN: begin
                case (phase_q)
                    MAIN:    main_lights = GRN3;
                    SEC:     sec_lights  = GRN3;
                    default: pea_lights  = PGRN;
                endcase
            end
            S_YELLOW: begin
                case (phase_q)
                    MAIN: main_lights = YEL3;
                    SEC:  sec_lights  = YEL3;
                    default: begin
`ifdef PED_FLASH_EN
                        pea_lights = halfOn ? PGRN : POFF;
`else
                        pea_lights = PRED;
`endif
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule
